// File: rtl/rgb2y_frame_gate_pkg.sv
// Shared video definitions for the RGB-to-luma front end of the histogram path.
// Holds the luma coefficients and rounding constant, the dv gate FSM state
// encoding and the default frame resolution.
package rgb2y_frame_gate_pkg;

    localparam int H_ACTIVE_DEF = 1280;
    localparam int V_ACTIVE_DEF = 720;
    localparam int CNT_W_DEF    = 21;

    // Coefficients sum to 256, so (sum + Y_RND) >> Y_SHIFT never exceeds 255.
    localparam logic [15:0] COEF_R  = 16'd77;
    localparam logic [15:0] COEF_G  = 16'd150;
    localparam logic [15:0] COEF_B  = 16'd29;
    localparam logic [15:0] Y_RND   = 16'd128;
    localparam int          Y_SHIFT = 8;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        IN_VS   = 2'd1,
        ACTIVE  = 2'd2
    } gate_state_t;

endpackage

// File: rtl/rgb2y_pipe.sv
// Three-stage luma datapath with a matching strobe delay line.
// Ports:
//   rx_clk, rst_n            pixel clock, async active-low reset
//   red_i/green_i/blue_i     8-bit colour components
//   dv_i, hs_i, vs_i         strobes (dv_i already gated by the caller)
//   y_o                      8-bit luma, 3 cycles after the input
//   dv_o, hs_o, vs_o         strobes delayed by 3 cycles
module rgb2y_pipe
    import rgb2y_frame_gate_pkg::*;
(
    input  logic       rx_clk,
    input  logic       rst_n,
    input  logic [7:0] red_i,
    input  logic [7:0] green_i,
    input  logic [7:0] blue_i,
    input  logic       dv_i,
    input  logic       hs_i,
    input  logic       vs_i,
    output logic [7:0] y_o,
    output logic       dv_o,
    output logic       hs_o,
    output logic       vs_o
);

    logic [15:0] r_prod_r;
    logic [15:0] r_prod_g;
    logic [15:0] r_prod_b;
    logic [15:0] r_sum;
    logic [7:0]  r_y;
    logic [2:0]  r_dv_dly;
    logic [2:0]  r_hs_dly;
    logic [2:0]  r_vs_dly;
    logic [15:0] w_rnd;
    logic [7:0]  w_y;

    // Max sum is 65280, plus rounding 65408: fits 16 bits with no carry out.
    assign w_rnd = r_sum + Y_RND;
    assign w_y   = 8'(w_rnd >> Y_SHIFT);

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod_r <= '0;
            r_prod_g <= '0;
            r_prod_b <= '0;
            r_sum    <= '0;
            r_y      <= '0;
            r_dv_dly <= '0;
            r_hs_dly <= '0;
            r_vs_dly <= '0;
        end else begin
            r_prod_r <= {8'd0, red_i}   * COEF_R;
            r_prod_g <= {8'd0, green_i} * COEF_G;
            r_prod_b <= {8'd0, blue_i}  * COEF_B;
            r_sum    <= r_prod_r + r_prod_g + r_prod_b;
            r_y      <= w_y;
            r_dv_dly <= {r_dv_dly[1:0], dv_i};
            r_hs_dly <= {r_hs_dly[1:0], hs_i};
            r_vs_dly <= {r_vs_dly[1:0], vs_i};
        end
    end

    assign y_o  = r_y;
    assign dv_o = r_dv_dly[2];
    assign hs_o = r_hs_dly[2];
    assign vs_o = r_vs_dly[2];

endmodule

// File: rtl/rgb2y_frame_gate.sv
// RGB to luma conversion with first-frame dv gating and per-frame pixel count.
// dv is held off until a complete vs pulse has been seen after reset, so the
// downstream histogram never sees a partial frame. Each vs rising edge while
// ACTIVE latches the pixel count and flags a size mismatch.
// Ports:
//   rx_clk, rst_n                 pixel clock, async active-low reset
//   red_i/green_i/blue_i          input pixel
//   dv_i, hs_i, vs_i              input strobes (vs rising edge = end of frame)
//   y_o, dv_o, hs_o, vs_o         luma and strobes, 3-cycle latency
//   frame_done_o                  one-cycle pulse when a count is latched
//   frame_pix_cnt_o               pixel count of the last completed frame
//   frame_err_o                   last count != H_ACTIVE*V_ACTIVE
module rgb2y_frame_gate
    import rgb2y_frame_gate_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             rx_clk,
    input  logic             rst_n,
    input  logic [7:0]       red_i,
    input  logic [7:0]       green_i,
    input  logic [7:0]       blue_i,
    input  logic             dv_i,
    input  logic             hs_i,
    input  logic             vs_i,
    output logic [7:0]       y_o,
    output logic             dv_o,
    output logic             hs_o,
    output logic             vs_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] frame_pix_cnt_o,
    output logic             frame_err_o
);

    localparam logic [CNT_W-1:0] LP_FRAME_PIX = CNT_W'(H_ACTIVE * V_ACTIVE);

    gate_state_t      r_state;
    logic             r_vs_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_vs_rise;
    logic             w_vs_fall;
    logic             w_dv_gated;

    assign w_vs_rise  = vs_i & ~r_vs_d;
    assign w_vs_fall  = ~vs_i & r_vs_d;
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    // Includes a pixel coincident with the vs rising edge in the latched count.
    assign w_cnt_next = dv_i ? w_cnt_inc : r_cnt;
    // Gate is sampled into the pipe's first stage together with dv_i.
    assign w_dv_gated = dv_i & (r_state == ACTIVE);

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= WAIT_VS;
            r_vs_d          <= 1'b0;
            r_cnt           <= '0;
            frame_done_o    <= 1'b0;
            frame_pix_cnt_o <= '0;
            frame_err_o     <= 1'b0;
        end else begin
            r_vs_d       <= vs_i;
            frame_done_o <= 1'b0;
            case (r_state)
                WAIT_VS: begin
                    if (w_vs_rise) r_state <= IN_VS;
                end
                IN_VS: begin
                    if (w_vs_fall) r_state <= ACTIVE;
                end
                ACTIVE: begin
                    if (w_vs_rise) begin
                        frame_pix_cnt_o <= w_cnt_next;
                        frame_err_o     <= (w_cnt_next != LP_FRAME_PIX);
                        frame_done_o    <= 1'b1;
                        r_cnt           <= '0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                default: r_state <= WAIT_VS;
            endcase
        end
    end

    rgb2y_pipe u_pipe (
        .rx_clk  (rx_clk),
        .rst_n   (rst_n),
        .red_i   (red_i),
        .green_i (green_i),
        .blue_i  (blue_i),
        .dv_i    (w_dv_gated),
        .hs_i    (hs_i),
        .vs_i    (vs_i),
        .y_o     (y_o),
        .dv_o    (dv_o),
        .hs_o    (hs_o),
        .vs_o    (vs_o)
    );

endmodule

// File: tb/tb_rgb2y_frame_gate.sv
module tb_rgb2y_frame_gate;

    logic        rx_clk = 1'b0;
    logic        rst_n;
    logic [7:0]  red_i, green_i, blue_i;
    logic        dv_i, hs_i, vs_i;
    logic [7:0]  y_o;
    logic        dv_o, hs_o, vs_o;
    logic        frame_done_o;
    logic [20:0] frame_pix_cnt_o;
    logic        frame_err_o;

    int checks   = 0;
    int failures = 0;

    rgb2y_frame_gate #(
        .H_ACTIVE (4),
        .V_ACTIVE (2),
        .CNT_W    (21)
    ) dut (
        .rx_clk          (rx_clk),
        .rst_n           (rst_n),
        .red_i           (red_i),
        .green_i         (green_i),
        .blue_i          (blue_i),
        .dv_i            (dv_i),
        .hs_i            (hs_i),
        .vs_i            (vs_i),
        .y_o             (y_o),
        .dv_o            (dv_o),
        .hs_o            (hs_o),
        .vs_o            (vs_o),
        .frame_done_o    (frame_done_o),
        .frame_pix_cnt_o (frame_pix_cnt_o),
        .frame_err_o     (frame_err_o)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic luma(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [7:0] exp_y, input string tag);
        red_i = r; green_i = g; blue_i = b; dv_i = 1'b1; hs_i = 1'b1;
        tick();
        dv_i = 1'b0; hs_i = 1'b0;
        tick();
        chk({tag, "_dv_early"}, 32'(dv_o), 32'd0);
        chk({tag, "_hs_early"}, 32'(hs_o), 32'd0);
        tick();
        chk({tag, "_y"},  32'(y_o),  32'(exp_y));
        chk({tag, "_dv"}, 32'(dv_o), 32'd1);
        chk({tag, "_hs"}, 32'(hs_o), 32'd1);
    endtask

    task automatic frame_px(input int n);
        for (int i = 0; i < n; i++) begin
            red_i = 8'(i * 40); green_i = 8'(i * 7); blue_i = 8'(255 - i);
            dv_i = 1'b1;
            tick();
        end
        dv_i = 1'b0;
    endtask

    task automatic vs_edge(input int exp_cnt, input logic exp_err, input string tag);
        vs_i = 1'b1;
        tick();
        chk({tag, "_done"}, 32'(frame_done_o), 32'd1);
        chk({tag, "_cnt"},  32'(frame_pix_cnt_o), 32'(exp_cnt));
        chk({tag, "_err"},  32'(frame_err_o), 32'(exp_err));
        tick();
        chk({tag, "_done_1cyc"}, 32'(frame_done_o), 32'd0);
        chk({tag, "_vs_o_early"}, 32'(vs_o), 32'd0);
        tick();
        chk({tag, "_vs_o_3cyc"}, 32'(vs_o), 32'd1);
        vs_i = 1'b0;
        tick();
        chk({tag, "_cnt_hold"}, 32'(frame_pix_cnt_o), 32'(exp_cnt));
    endtask

    initial begin
        rst_n = 1'b1;
        red_i = '0; green_i = '0; blue_i = '0;
        dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_y",    32'(y_o), 32'd0);
        chk("rst_dv",   32'(dv_o), 32'd0);
        chk("rst_hs",   32'(hs_o), 32'd0);
        chk("rst_vs",   32'(vs_o), 32'd0);
        chk("rst_done", 32'(frame_done_o), 32'd0);
        chk("rst_cnt",  32'(frame_pix_cnt_o), 32'd0);
        chk("rst_err",  32'(frame_err_o), 32'd0);

        // Release mid-frame with pixels already flowing: must stay gated.
        red_i = 8'd255; green_i = 8'd255; blue_i = 8'd255; dv_i = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dv_i = (i < 3);
            tick();
            chk("gate_pre_vs_dv",   32'(dv_o), 32'd0);
            chk("gate_pre_vs_done", 32'(frame_done_o), 32'd0);
        end

        // First vs pulse: no frame_done, opens the gate on its falling edge.
        vs_i = 1'b1;
        tick();
        chk("first_vs_done", 32'(frame_done_o), 32'd0);
        tick();
        chk("first_vs_done2", 32'(frame_done_o), 32'd0);
        vs_i = 1'b0;
        tick();

        luma(8'd255, 8'd255, 8'd255, 8'd255, "white");
        luma(8'd0,   8'd0,   8'd0,   8'd0,   "black");
        luma(8'd255, 8'd0,   8'd0,   8'd77,  "red");
        luma(8'd0,   8'd255, 8'd0,   8'd149, "green");
        luma(8'd0,   8'd0,   8'd255, 8'd29,  "blue");
        luma(8'd100, 8'd150, 8'd200, 8'd141, "mix");
        vs_edge(6, 1'b1, "luma_frame");

        frame_px(8);
        vs_edge(8, 1'b0, "good");

        frame_px(7);
        vs_edge(7, 1'b1, "short");
        frame_px(8);
        vs_edge(8, 1'b0, "recover");

        // 8th pixel coincides with the vs rising edge.
        frame_px(7);
        dv_i = 1'b1; vs_i = 1'b1;
        tick();
        chk("coin_done", 32'(frame_done_o), 32'd1);
        chk("coin_cnt",  32'(frame_pix_cnt_o), 32'd8);
        chk("coin_err",  32'(frame_err_o), 32'd0);
        dv_i = 1'b0;
        tick();
        tick();
        vs_i = 1'b0;
        tick();
        frame_px(8);
        vs_edge(8, 1'b0, "after_coin");

        // Mid-frame reset.
        for (int i = 0; i < 4; i++) begin
            red_i = 8'd10; green_i = 8'd20; blue_i = 8'd30; dv_i = 1'b1;
            tick();
        end
        chk("pre_rst_dv", 32'(dv_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_y",    32'(y_o), 32'd0);
        chk("mrst_dv",   32'(dv_o), 32'd0);
        chk("mrst_hs",   32'(hs_o), 32'd0);
        chk("mrst_vs",   32'(vs_o), 32'd0);
        chk("mrst_done", 32'(frame_done_o), 32'd0);
        chk("mrst_cnt",  32'(frame_pix_cnt_o), 32'd0);
        chk("mrst_err",  32'(frame_err_o), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_gated", 32'(dv_o), 32'd0);
        end
        dv_i = 1'b0; vs_i = 1'b1;
        tick();
        chk("post_rst_vs_done", 32'(frame_done_o), 32'd0);
        tick();
        // Pixel on the vs falling-edge cycle is still gated and not counted.
        vs_i = 1'b0; dv_i = 1'b1;
        tick();
        chk("fall_px_a", 32'(dv_o), 32'd0);
        tick();
        chk("fall_px_b", 32'(dv_o), 32'd0);
        tick();
        chk("fall_px_c", 32'(dv_o), 32'd0);
        tick();
        chk("first_px_dv", 32'(dv_o), 32'd1);
        dv_i = 1'b0;
        vs_edge(3, 1'b1, "post_rst_frame");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb2y_frame_gate.md
Name: rgb2y_frame_gate

Overview:
- Upstream neighbour of the histogram stage, in the rx_clk video domain.
- Converts 24-bit RGB video to 8-bit luma Y and delays the data-valid and sync strobes to match the pipeline.
- Suppresses data-valid until the first complete frame after reset, so the histogram never accumulates a partial frame.
- Counts pixels per frame and flags frames whose size differs from the configured resolution.

Parameters:
- H_ACTIVE, 1280, active pixels per line.
- V_ACTIVE, 720, active lines per frame.
- CNT_W, 21, width of the pixel counter. Must satisfy 2^CNT_W > H_ACTIVE*V_ACTIVE.

Ports:
- rx_clk  input  1  pixel clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- red_i  input  8  red component.
- green_i  input  8  green component.
- blue_i  input  8  blue component.
- dv_i  input  1  pixel valid.
- hs_i  input  1  horizontal sync, active high.
- vs_i  input  1  vertical sync, active high; its rising edge marks end of frame.
- y_o  output  8  luma.
- dv_o  output  1  gated pixel valid, aligned with y_o.
- hs_o  output  1  hs_i delayed by 3 cycles.
- vs_o  output  1  vs_i delayed by 3 cycles; feeds the histogram end_of_frame.
- frame_done_o  output  1  one-cycle pulse when a frame count is latched.
- frame_pix_cnt_o  output  CNT_W  pixel count of the last completed frame.
- frame_err_o  output  1  last completed frame count != H_ACTIVE*V_ACTIVE.

Behaviour:
- Reset: all outputs and internal registers are 0 and the FSM enters WAIT_VS. Reset assertion mid-frame discards everything immediately.
- Luma arithmetic: Y = (77*R + 150*G + 29*B + 128) >> 8, computed unsigned in 16 bits. Coefficients sum to 256, so the maximum result is 255 and no saturation logic is needed.
- Pipeline, fixed latency 3 cycles from input to y_o, with no stall or backpressure:
  - S1 registers the three products.
  - S2 registers the sum.
  - S3 registers the rounded, shifted result.
- Strobes: dv, hs and vs pass through a matching 3-stage delay line. hs_o and vs_o are never gated.
- FSM, evaluated on the input side before the delay:
  - WAIT_VS: dv gate closed. On a vs_i rising edge (vs_i=1 and previous vs_i=0), go to IN_VS.
  - IN_VS: gate closed. On a vs_i falling edge, go to ACTIVE.
  - ACTIVE: gate open, dv_o = delayed dv_i. Remain here; a vs_i rising edge triggers frame-end handling but keeps the state ACTIVE.
- Gate timing: the gate decision is registered alongside dv_i at S1, so pixel k of the first full frame appears on dv_o exactly 3 cycles after its dv_i.
- Pixel counter (ACTIVE only):
  - Increments on each dv_i=1 cycle and saturates at all-ones.
  - On a vs_i rising edge in ACTIVE, the next cycle (1 cycle after the edge) does three things together: latches frame_pix_cnt_o, sets frame_err_o = (count != H_ACTIVE*V_ACTIVE), and pulses frame_done_o.
  - The counter clears on that same edge.
- Coincident dv_i=1 and vs_i rising edge: that pixel is included in the latched count, and the cleared counter starts at 0.
- dv_i while vs_i=1 in ACTIVE: counted into the next frame. This is a legal but abnormal condition, and the resulting frame_err_o reflects it.
- frame_pix_cnt_o and frame_err_o hold their values until the next frame_done_o. frame_err_o may be re-evaluated to 0.
- The first vs_i rising edge after reset (WAIT_VS to IN_VS) produces no frame_done_o.

Decomposition:
- Shared video package holds:
  - luma coefficients and rounding constant: COEF_R=77, COEF_G=150, COEF_B=29, Y_RND=128, Y_SHIFT=8;
  - FSM state encoding: WAIT_VS, IN_VS, ACTIVE;
  - the default resolution constants.
- One natural sub-module, rgb2y_pipe: the 3-stage luma datapath plus its strobe delay line.
- The top level holds the FSM, the gating and the frame counter.

Test Plan:
- Reset and gating: H_ACTIVE=4, V_ACTIVE=2, rst_n released mid-frame, 3 pixels with dv_i=1 before any vs_i. Require dv_o=0 throughout and frame_done_o never asserted.
- Luma values, checked 3 cycles after dv_i once in ACTIVE:
  - RGB (255,255,255) gives y_o=255.
  - (0,0,0) gives 0.
  - (255,0,0) gives 77.
  - (0,255,0) gives 149.
  - (0,0,255) gives 29.
  - (100,150,200) gives 141.
- Good frame: vs pulse, then 8 valid pixels, then vs rising edge. Require frame_done_o for exactly 1 cycle, frame_pix_cnt_o=8, frame_err_o=0, and vs_o rising 3 cycles after vs_i.
- Short frame: 7 pixels, then a vs rising edge. Require frame_pix_cnt_o=7 and frame_err_o=1. A following 8-pixel frame returns frame_err_o to 0.
- Coincident dv_i=1 with the vs_i rising edge on the 8th pixel: require frame_pix_cnt_o=8, and the next frame's count starts from 0.
- Mid-frame reset: pull rst_n low after 4 pixels in ACTIVE. Require all outputs 0 asynchronously and the FSM in WAIT_VS; after release, the next frame is gated until a full vs pulse has passed.
